// File: rtl/duty_seq_pkg.sv
// Shared types and constants for the duty sequencer.
//   mode_e      : sequencer operating mode (SHIFT, FADE, STATIC, HOLD)
//   N_CH        : number of PWM channels
//   DUTY_W      : width of one duty value
//   duty_arr_t  : per-channel duty bank, unpacked, indexed 0..N_CH-1
//   shift_seed  : reset/SHIFT-entry duty value for a channel, {ch[3:0], 4'hF}
package duty_seq_pkg;

  localparam int N_CH   = 16;
  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    SHIFT  = 2'b00,
    FADE   = 2'b01,
    STATIC = 2'b10,
    HOLD   = 2'b11
  } mode_e;

  typedef logic [DUTY_W-1:0] duty_arr_t [N_CH];

  function automatic logic [DUTY_W-1:0] shift_seed(input int ch);
    logic [3:0] idx;
    idx = ch[3:0];
    return {idx, 4'hF};
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step divider.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears the count
//   tick  : high for the single cycle in which the count equals DIV-1
module tick_divider #(
  parameter int unsigned DIV = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(DIV - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Decoded straight from the count so the pulse lines up with count == DIV-1.
  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 32'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/duty_sequencer.sv
// Sixteen-channel PWM duty sequencer with debounced mode select.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   switches  : raw board switches; [15:14] select mode, [15:0] are STATIC data
//   duty      : registered per-channel duty values
//   step_tick : one-cycle pulse per sequence step (runs in every mode)
//   mode      : currently active, debounced mode
module duty_sequencer
  import duty_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 2_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned STEP            = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] switches,
  output duty_arr_t   duty,
  output logic        step_tick,
  output logic [1:0]  mode
);

  localparam logic [24:0]       STAB_MAX = 25'(DEBOUNCE_CYCLES - 1);
  localparam logic [DUTY_W-1:0] STEP_B   = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] LVL_MAX  = '1;

  logic [15:0]       sync1_q, sync2_q;
  mode_e             cand_q, mode_q, mode_d, sync_mode;
  logic [24:0]       stab_q, stab_d;
  logic              mode_chg;
  logic [DUTY_W-1:0] level_q, level_d;
  logic              dir_down_q, dir_down_d;
  duty_arr_t         duty_q, duty_d;

  tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (step_tick)
  );

  assign sync_mode = mode_e'(sync2_q[15:14]);

  // Debounce: the candidate follows the synchronized select every cycle; the
  // stability counter measures how long the two have agreed.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    stab_d = stab_q;
    if (sync_mode != cand_q)    stab_d = '0;
    else if (stab_q != STAB_MAX) stab_d = stab_q + 25'd1;
  end

  assign mode_chg = (stab_q == STAB_MAX) && (cand_q != mode_q);
  assign mode_d   = mode_chg ? cand_q : mode_q;

  // Duty update. A mode change takes priority over a coincident step tick, so
  // the entry load (or, for STATIC/HOLD, a one-cycle hold) always wins.
  always_comb begin
    duty_d     = duty_q;
    level_d    = level_q;
    dir_down_d = dir_down_q;
    if (mode_chg) begin
      case (cand_q)
        SHIFT: for (int i = 0; i < N_CH; i++) duty_d[i] = shift_seed(i);
        FADE: begin
          level_d    = '0;
          dir_down_d = 1'b0;
          for (int i = 0; i < N_CH; i++) duty_d[i] = '0;
        end
        default: ;
      endcase
    end else begin
      case (mode_q)
        SHIFT: begin
          if (step_tick) begin
            duty_d[0] = duty_q[N_CH-1];
            for (int i = 1; i < N_CH; i++) duty_d[i] = duty_q[i-1];
          end
        end
        FADE: begin
          if (step_tick) begin
            // Saturate at the rails and reverse instead of wrapping.
            if (!dir_down_q) begin
              if (level_q > LVL_MAX - STEP_B) begin
                level_d    = LVL_MAX;
                dir_down_d = 1'b1;
              end else begin
                level_d = level_q + STEP_B;
              end
            end else begin
              if (level_q < STEP_B) begin
                level_d    = '0;
                dir_down_d = 1'b0;
              end else begin
                level_d = level_q - STEP_B;
              end
            end
            for (int i = 0; i < N_CH; i++) duty_d[i] = level_d;
          end
        end
        STATIC: begin
          for (int i = 0; i < N_CH; i++) duty_d[i] = sync2_q[i] ? LVL_MAX : '0;
        end
        default: ; // HOLD: duty frozen
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= SHIFT;
      stab_q     <= '0;
      mode_q     <= SHIFT;
      level_q    <= '0;
      dir_down_q <= 1'b0;
      // NOTE: the duty bank is a flop array with a defined power-up pattern,
      // not a RAM, so it is reset element by element.
      for (int i = 0; i < N_CH; i++) duty_q[i] <= shift_seed(i);
    end else begin
      // Raw switches are asynchronous; only sync2_q is used downstream.
      sync1_q    <= switches;
      sync2_q    <= sync1_q;
      cand_q     <= sync_mode;
      stab_q     <= stab_d;
      mode_q     <= mode_d;
      level_q    <= level_d;
      dir_down_q <= dir_down_d;
      duty_q     <= duty_d;
    end
  end

  assign duty = duty_q;
  assign mode = mode_q;

endmodule
